// File: rtl/hams_pkg.sv
// Shared types and constants for the hams sorter traffic generator / checker.
package hams_pkg;

  localparam int unsigned N_ELEM        = 8;
  localparam int unsigned KEY_W         = 32;
  localparam int unsigned TAG_W         = 16;
  localparam int unsigned SIG_DEPTH     = 16;
  localparam int unsigned DRAIN_TIMEOUT = 1024;
  localparam int unsigned SUM_W         = KEY_W + $clog2(N_ELEM);
  localparam int unsigned CNT_W         = 16;
  localparam int unsigned LFSR_W        = 32;

  localparam logic [LFSR_W-1:0] LFSR_MASK = 32'h8020_0003;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [TAG_W-1:0] tag;
  } pair_t;

  typedef pair_t [N_ELEM-1:0] frame_t;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [TAG_W-1:0] x;
  } sig_t;

  typedef enum logic [1:0] {
    GEN_DESC  = 2'd0,
    GEN_ASC   = 2'd1,
    GEN_RAND  = 2'd2,
    GEN_CONST = 2'd3
  } gen_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One Galois step of the 32-bit LFSR.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : '0);
  endfunction

  // Saturating counter increment.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Content signature of a frame: modular key sum and tag XOR.
  function automatic sig_t frame_sig(input frame_t f);
    sig_t s;
    s = '0;
    for (int i = 0; i < int'(N_ELEM); i++) begin
      s.sum = s.sum + SUM_W'(f[i].key);
      s.x   = s.x ^ f[i].tag;
    end
    return s;
  endfunction

endpackage

// File: rtl/hams_sig_fifo.sv
// In-order signature FIFO; push+pop together is legal when full, pop on empty is ignored.
module hams_sig_fifo
  import hams_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic push_i,
  input  sig_t push_data_i,
  input  logic pop_i,
  output sig_t head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  sig_t             mem_q [DEPTH];
  logic [PTR_W:0]   wr_q, wr_d;
  logic [PTR_W:0]   rd_q, rd_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Pointer update and next-cycle full/empty flags.
  always_comb begin
    do_pop  = pop_i & ~empty_q;
    do_push = push_i & (~full_q | do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (clr_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + (PTR_W+1)'(1);
      if (do_pop)  rd_d = rd_q + (PTR_W+1)'(1);
    end
    empty_d = (wr_d == rd_d);
    full_d  = (wr_d[PTR_W] != rd_d[PTR_W]) && (wr_d[PTR_W-1:0] == rd_d[PTR_W-1:0]);
  end

  // Pointer and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_q[PTR_W-1:0]] <= push_data_i;
  end

  assign head_o  = mem_q[rd_q[PTR_W-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/hams_sort_tgen_chk.sv
// Traffic generator and in-order self-checker for the hams_sortNelem sorter.
module hams_sort_tgen_chk
  import hams_pkg::*;
#(
  parameter int unsigned SIG_DEPTH_P     = SIG_DEPTH,
  parameter int unsigned DRAIN_TIMEOUT_P = DRAIN_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  num_frames,
  input  logic [LFSR_W-1:0] seed,
  output frame_t            unsorted,
  output logic              valid,
  input  frame_t            sorted,
  input  logic              valid_o,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  frames_sent,
  output logic [CNT_W-1:0]  frames_checked,
  output logic [CNT_W-1:0]  err_order,
  output logic [CNT_W-1:0]  err_sig,
  output logic [CNT_W-1:0]  err_spurious
);

  localparam int unsigned DRAIN_W = $clog2(DRAIN_TIMEOUT_P + 1);

  state_e             state_q, state_d;
  gen_mode_e          mode_q, mode_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [LFSR_W-1:0]  seed_q, seed_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  frame_t             unsorted_q, unsorted_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   sent_q, sent_d;
  logic [CNT_W-1:0]   checked_q, checked_d;
  logic [CNT_W-1:0]   eord_q, eord_d;
  logic [CNT_W-1:0]   esig_q, esig_d;
  logic [CNT_W-1:0]   espur_q, espur_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;

  frame_t             gen_frame;
  logic [LFSR_W-1:0]  lfsr_w;
  logic [KEY_W-1:0]   key_v;
  logic               order_ok;
  logic               sig_ok;
  logic               fifo_clr, fifo_push, fifo_pop;
  logic               fifo_full, fifo_empty;
  sig_t               fifo_head;

  // Candidate frame for the current mode; LFSR advances once per element.
  always_comb begin
    gen_frame = '0;
    lfsr_w    = lfsr_q;
    key_v     = '0;
    for (int i = 0; i < int'(N_ELEM); i++) begin
      case (mode_q)
        GEN_DESC: key_v = KEY_W'(int'(N_ELEM) - i);
        GEN_ASC:  key_v = KEY_W'(i + 1);
        GEN_RAND: key_v = KEY_W'(lfsr_w);
        default:  key_v = KEY_W'(seed_q);
      endcase
      gen_frame[i].key = key_v;
      gen_frame[i].tag = TAG_W'(i);
      lfsr_w           = lfsr_step(lfsr_w);
    end
  end

  // Order and signature evaluation of the returning frame.
  always_comb begin
    order_ok = 1'b1;
    for (int i = 0; i < int'(N_ELEM) - 1; i++) begin
      if (sorted[i].key > sorted[i+1].key) order_ok = 1'b0;
    end
    sig_ok = (frame_sig(sorted) == fifo_head);
  end

  // Next-state, generator, checker and counter logic.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    num_d      = num_q;
    seed_d     = seed_q;
    lfsr_d     = lfsr_q;
    unsorted_d = unsorted_q;
    valid_d    = 1'b0;
    timeout_d  = timeout_q;
    sent_d     = sent_q;
    checked_d  = checked_q;
    eord_d     = eord_q;
    esig_d     = esig_q;
    espur_d    = espur_q;
    drain_d    = drain_q;
    fifo_clr   = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;

    // Checker runs in every state; a start clear below takes priority.
    if (valid_o) begin
      if (fifo_empty) begin
        espur_d = sat_inc(espur_q);
      end else begin
        fifo_pop  = 1'b1;
        checked_d = sat_inc(checked_q);
        if (!order_ok) eord_d = sat_inc(eord_q);
        if (!sig_ok)   esig_d = sat_inc(esig_q);
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RUN;
          mode_d    = gen_mode_e'(mode);
          num_d     = num_frames;
          seed_d    = seed;
          lfsr_d    = (seed == '0) ? LFSR_W'(1) : seed;
          timeout_d = 1'b0;
          sent_d    = '0;
          checked_d = '0;
          eord_d    = '0;
          esig_d    = '0;
          espur_d   = '0;
          fifo_clr  = 1'b1;
        end
      end
      ST_RUN: begin
        drain_d = '0;
        if ((sent_q < num_q) && !fifo_full) begin
          valid_d    = 1'b1;
          unsorted_d = gen_frame;
          lfsr_d     = lfsr_w;
          fifo_push  = 1'b1;
          sent_d     = sat_inc(sent_q);
        end
        if (sent_d == num_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (checked_q == sent_q) begin
          state_d = ST_DONE;
        end else if (drain_q == DRAIN_W'(DRAIN_TIMEOUT_P - 1)) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= GEN_DESC;
      num_q      <= '0;
      seed_q     <= '0;
      lfsr_q     <= LFSR_W'(1);
      unsorted_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      sent_q     <= '0;
      checked_q  <= '0;
      eord_q     <= '0;
      esig_q     <= '0;
      espur_q    <= '0;
      drain_q    <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      num_q      <= num_d;
      seed_q     <= seed_d;
      lfsr_q     <= lfsr_d;
      unsorted_q <= unsorted_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      sent_q     <= sent_d;
      checked_q  <= checked_d;
      eord_q     <= eord_d;
      esig_q     <= esig_d;
      espur_q    <= espur_d;
      drain_q    <= drain_d;
    end
  end

  hams_sig_fifo #(
    .DEPTH (SIG_DEPTH_P)
  ) u_sig_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (fifo_clr),
    .push_i      (fifo_push),
    .push_data_i (frame_sig(gen_frame)),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign unsorted       = unsorted_q;
  assign valid          = valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout        = timeout_q;
  assign frames_sent    = sent_q;
  assign frames_checked = checked_q;
  assign err_order      = eord_q;
  assign err_sig        = esig_q;
  assign err_spurious   = espur_q;

endmodule

// File: tb/tb_hams_sort_tgen_chk.sv
// Directed bench: behavioural sorter with programmable latency and fault injection.
module tb_hams_sort_tgen_chk;
  import hams_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [1:0]        mode;
  logic [CNT_W-1:0]  num_frames;
  logic [LFSR_W-1:0] seed;
  frame_t            unsorted;
  logic              valid;
  frame_t            sorted;
  logic              valid_o;
  logic              busy, done, timeout;
  logic [CNT_W-1:0]  frames_sent, frames_checked, err_order, err_sig, err_spurious;

  int n_chk  = 0;
  int n_pass = 0;

  // Sorter model controls.
  int     lat           = 1;
  int     swap_frame    = -1;
  int     corrupt_frame = -1;
  int     drop_frame    = -1;
  logic   force_vo      = 1'b0;
  logic   tb_flush      = 1'b1;
  int     frm_cnt       = 0;
  frame_t pipe_f [64];
  logic   pipe_v [64];

  always #5 clk = ~clk;

  hams_sort_tgen_chk dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .mode           (mode),
    .num_frames     (num_frames),
    .seed           (seed),
    .unsorted       (unsorted),
    .valid          (valid),
    .sorted         (sorted),
    .valid_o        (valid_o),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout),
    .frames_sent    (frames_sent),
    .frames_checked (frames_checked),
    .err_order      (err_order),
    .err_sig        (err_sig),
    .err_spurious   (err_spurious)
  );

  function automatic frame_t sort_frame(input frame_t f);
    frame_t r;
    pair_t  t;
    r = f;
    for (int i = 1; i < int'(N_ELEM); i++)
      for (int j = i; j > 0; j--)
        if (r[j-1].key > r[j].key) begin
          t = r[j]; r[j] = r[j-1]; r[j-1] = t;
        end
    return r;
  endfunction

  // Ideal in-order sorter with a delay line; survives DUT reset on purpose.
  always @(posedge clk) begin
    frame_t s;
    logic [KEY_W-1:0] k;
    s = sort_frame(unsorted);
    if (frm_cnt == swap_frame) begin
      k = s[0].key; s[0].key = s[1].key; s[1].key = k;
    end
    if (frm_cnt == corrupt_frame) s[N_ELEM-1].key = s[N_ELEM-1].key + 1;
    for (int i = 63; i > 0; i--) begin
      pipe_f[i] <= tb_flush ? '0 : pipe_f[i-1];
      pipe_v[i] <= tb_flush ? 1'b0 : pipe_v[i-1];
    end
    pipe_f[0] <= tb_flush ? '0 : s;
    pipe_v[0] <= !tb_flush && valid && (frm_cnt != drop_frame);
    if (valid) frm_cnt <= frm_cnt + 1;
  end

  assign valid_o = pipe_v[lat-1] | force_vo;
  assign sorted  = pipe_f[lat-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_sorter();
    tb_flush = 1'b1;
    tick();
    tb_flush = 1'b0;
  endtask

  task automatic start_run(input logic [1:0] m, input logic [CNT_W-1:0] n, input logic [LFSR_W-1:0] sd);
    mode = m; num_frames = n; seed = sd; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs until done or budget, recording valid activity and the first frame.
  task automatic run_to_done(input string nm, input int budget, output int cyc,
                             output int nval, output int run1, output frame_t first_f);
    bit over;
    over = 0; cyc = 0; nval = 0; run1 = 0; first_f = '0;
    while (done !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
      if (valid === 1'b1) begin
        if (nval == 0) first_f = unsorted;
        nval++;
        if (!over) run1++;
      end else if (run1 > 0) over = 1;
    end
    n_chk++;
    if (done !== 1'b1) $display("FAIL %s_done_wait got done=%b after %0d cycles exp 1", nm, done, cyc);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = '0; num_frames = '0; seed = '0; tb_flush = 1'b1;
    repeat (3) tick();
    n_chk++; if (valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", valid); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done); else n_pass++;
    n_chk++; if (timeout !== 1'b0) $display("FAIL rst_timeout got %b exp 0", timeout); else n_pass++;
    n_chk++; if (unsorted !== '0) $display("FAIL rst_unsorted got %h exp 0", unsorted); else n_pass++;
    n_chk++; if (frames_sent !== '0) $display("FAIL rst_sent got %0d exp 0", frames_sent); else n_pass++;
    n_chk++; if (frames_checked !== '0) $display("FAIL rst_checked got %0d exp 0", frames_checked); else n_pass++;
    n_chk++; if ({err_order, err_sig, err_spurious} !== '0)
      $display("FAIL rst_errs got %0d/%0d/%0d exp 0/0/0", err_order, err_sig, err_spurious); else n_pass++;
    rst_n = 1'b1;
    tick();
    tb_flush = 1'b0;
    tick();
  endtask

  task automatic test_spurious_idle();
    force_vo = 1'b1;
    tick();
    force_vo = 1'b0;
    tick();
    n_chk++; if (err_spurious !== 16'd1) $display("FAIL idle_spurious got %0d exp 1", err_spurious); else n_pass++;
    n_chk++; if (frames_checked !== 16'd0) $display("FAIL idle_checked got %0d exp 0", frames_checked); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL idle_busy got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_desc();
    int cyc, nval, run1;
    frame_t f, exp_f;
    flush_sorter();
    lat = 1;
    start_run(2'd0, 16'd20, 32'd0);
    run_to_done("desc", 200, cyc, nval, run1, f);
    for (int i = 0; i < int'(N_ELEM); i++) begin
      exp_f[i].key = KEY_W'(8 - i);
      exp_f[i].tag = TAG_W'(i);
    end
    n_chk++; if (f !== exp_f) $display("FAIL desc_first_frame got %h exp %h", f, exp_f); else n_pass++;
    n_chk++; if (nval != 20) $display("FAIL desc_valid_count got %0d exp 20", nval); else n_pass++;
    n_chk++; if (run1 != 20) $display("FAIL desc_valid_burst got %0d exp 20", run1); else n_pass++;
    n_chk++; if (frames_sent !== 16'd20) $display("FAIL desc_sent got %0d exp 20", frames_sent); else n_pass++;
    n_chk++; if (frames_checked !== 16'd20) $display("FAIL desc_checked got %0d exp 20", frames_checked); else n_pass++;
    n_chk++; if ({err_order, err_sig, err_spurious} !== '0)
      $display("FAIL desc_errs got %0d/%0d/%0d exp 0/0/0", err_order, err_sig, err_spurious); else n_pass++;
    n_chk++; if (timeout !== 1'b0 || busy !== 1'b0) $display("FAIL desc_flags got to=%b busy=%b exp 0 0", timeout, busy); else n_pass++;
  endtask

  task automatic test_zero_frames();
    int cyc, nval, run1;
    frame_t f;
    flush_sorter();
    start_run(2'd1, 16'd0, 32'd0);
    run_to_done("zero", 20, cyc, nval, run1, f);
    n_chk++; if (cyc != 2) $display("FAIL zero_cycles got %0d exp 2", cyc); else n_pass++;
    n_chk++; if (frames_sent !== 16'd0 || nval != 0) $display("FAIL zero_sent got %0d valid %0d exp 0 0", frames_sent, nval); else n_pass++;
  endtask

  task automatic test_rand_seed();
    int cyc, nval, run1;
    frame_t f0, f1;
    logic [KEY_W-1:0] exp_k [5];
    exp_k[0] = 32'h0000_0001; exp_k[1] = 32'h8020_0003; exp_k[2] = 32'hC030_0002;
    exp_k[3] = 32'h6018_0001; exp_k[4] = 32'hB02C_0003;
    flush_sorter();
    start_run(2'd2, 16'd2, 32'd0);
    run_to_done("rand_s0", 100, cyc, nval, run1, f0);
    flush_sorter();
    start_run(2'd2, 16'd2, 32'd1);
    run_to_done("rand_s1", 100, cyc, nval, run1, f1);
    n_chk++; if (f0 !== f1) $display("FAIL rand_seed0_vs_1 got %h exp %h", f0, f1); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (f1[i].key !== exp_k[i]) $display("FAIL rand_key%0d got %h exp %h", i, f1[i].key, exp_k[i]);
      else n_pass++;
    end
    n_chk++; if ({err_order, err_sig} !== '0) $display("FAIL rand_errs got %0d/%0d exp 0/0", err_order, err_sig); else n_pass++;
  endtask

  task automatic test_swap();
    int cyc, nval, run1;
    frame_t f;
    flush_sorter();
    swap_frame = frm_cnt + 3;
    start_run(2'd2, 16'd10, 32'd1);
    run_to_done("swap", 200, cyc, nval, run1, f);
    swap_frame = -1;
    n_chk++; if (err_order !== 16'd1) $display("FAIL swap_order got %0d exp 1", err_order); else n_pass++;
    n_chk++; if (err_sig !== 16'd0) $display("FAIL swap_sig got %0d exp 0", err_sig); else n_pass++;
    n_chk++; if (frames_checked !== 16'd10) $display("FAIL swap_checked got %0d exp 10", frames_checked); else n_pass++;
  endtask

  task automatic test_corrupt();
    int cyc, nval, run1;
    frame_t f;
    flush_sorter();
    corrupt_frame = frm_cnt + 5;
    start_run(2'd1, 16'd10, 32'd0);
    run_to_done("corrupt", 200, cyc, nval, run1, f);
    corrupt_frame = -1;
    n_chk++; if (err_sig !== 16'd1) $display("FAIL corrupt_sig got %0d exp 1", err_sig); else n_pass++;
    n_chk++; if (err_order !== 16'd0) $display("FAIL corrupt_order got %0d exp 0", err_order); else n_pass++;
  endtask

  task automatic test_latency();
    int cyc, nval, run1;
    frame_t f;
    flush_sorter();
    lat = 40;
    start_run(2'd1, 16'd20, 32'd0);
    run_to_done("lat40", 500, cyc, nval, run1, f);
    n_chk++; if (run1 != 16) $display("FAIL lat40_burst got %0d exp 16", run1); else n_pass++;
    n_chk++; if (nval != 20) $display("FAIL lat40_valid_count got %0d exp 20", nval); else n_pass++;
    n_chk++; if (frames_checked !== 16'd20) $display("FAIL lat40_checked got %0d exp 20", frames_checked); else n_pass++;
    n_chk++; if ({err_order, err_sig, err_spurious} !== '0 || timeout !== 1'b0)
      $display("FAIL lat40_errs got %0d/%0d/%0d to=%b exp 0", err_order, err_sig, err_spurious, timeout); else n_pass++;
    lat = 1;
  endtask

  task automatic test_drop();
    int cyc, nval, run1;
    frame_t f;
    flush_sorter();
    drop_frame = frm_cnt + 7;
    start_run(2'd0, 16'd20, 32'd0);
    run_to_done("drop", 2000, cyc, nval, run1, f);
    drop_frame = -1;
    n_chk++; if (cyc != 1044) $display("FAIL drop_done_cycle got %0d exp 1044", cyc); else n_pass++;
    n_chk++; if (timeout !== 1'b1) $display("FAIL drop_timeout got %b exp 1", timeout); else n_pass++;
    n_chk++; if (frames_checked !== 16'd19) $display("FAIL drop_checked got %0d exp 19", frames_checked); else n_pass++;
    n_chk++; if (frames_sent !== 16'd20) $display("FAIL drop_sent got %0d exp 20", frames_sent); else n_pass++;
    n_chk++; if ({err_order, err_sig} !== '0) $display("FAIL drop_errs got %0d/%0d exp 0/0", err_order, err_sig); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    int late;
    flush_sorter();
    lat = 40;
    start_run(2'd1, 16'd20, 32'd0);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    n_chk++; if (frames_sent !== '0 || valid !== 1'b0) $display("FAIL midrst_sent got %0d valid %b exp 0 0", frames_sent, valid); else n_pass++;
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midrst_state got busy=%b done=%b exp 0 0", busy, done); else n_pass++;
    tick();
    rst_n = 1'b1;
    late = 0;
    repeat (60) begin
      tick();
      if (valid_o === 1'b1) late++;
    end
    tick();
    n_chk++; if (err_spurious !== CNT_W'(late)) $display("FAIL midrst_spurious got %0d exp %0d", err_spurious, late); else n_pass++;
    n_chk++; if (frames_checked !== '0) $display("FAIL midrst_checked got %0d exp 0", frames_checked); else n_pass++;
    n_chk++; if ({err_order, err_sig} !== '0) $display("FAIL midrst_errs got %0d/%0d exp 0/0", err_order, err_sig); else n_pass++;
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midrst_idle got busy=%b done=%b exp 0 0", busy, done); else n_pass++;
    lat = 1;
  endtask

  initial begin
    test_reset();
    test_spurious_idle();
    test_desc();
    test_zero_frames();
    test_rand_seed();
    test_swap();
    test_corrupt();
    test_latency();
    test_drop();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
